// File: rtl/credit_tx.sv
// -----------------------------------------------------------------------------
// credit_tx -- credit-based transmitter feeding a downstream FIFO write port.
//
// Upstream words are accepted with a valid/ready handshake and written to the
// downstream FIFO exactly one clock later.  A credit counter, preloaded with
// CREDITS, tracks free downstream FIFO slots: each write consumes one credit
// and each credit_ret pulse (one per word the consumer reads) returns one.
// Two INIT states after reset give the downstream FIFO time to leave its own
// registered reset before any write is issued.
//
// Parameters:
//   WIDTH       data width in bits (1..64)
//   CREDITS     initial and maximum credit count (1..15)
//
// Ports:
//   clk         clock, rising edge
//   reset_n     asynchronous active-low reset
//   s_data      upstream data
//   s_valid     upstream data valid
//   s_ready     block accepts s_data this cycle (combinational)
//   data_o      data to downstream FIFO write port (registered)
//   data_we     downstream FIFO write enable (registered)
//   credit_ret  one-cycle credit return pulse from the consumer
//   credits     current credit count
//   err         sticky credit-overflow flag
//
// Optional feature macro:
//   CREDIT_TX_OVERFLOW_CHECK_EN  when defined, a credit return arriving while
//                                the count is already full (and no transfer
//                                is consuming one) sets err until reset.
//                                When undefined, err is tied to 0.
// -----------------------------------------------------------------------------
module credit_tx #(
    parameter int WIDTH   = 8,
    parameter int CREDITS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] data_o,
    output logic             data_we,
    input  logic             credit_ret,
    output logic [3:0]       credits,
    output logic             err
);

    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    typedef enum logic [1:0] {
        INIT0  = 2'd0,
        INIT1  = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [3:0]       count_q;
    logic [3:0]       count_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             we_q;
    logic             we_d;

    logic             active_s;
    logic             xfer_s;
    logic             ret_s;

    // Handshake decode: ready depends only on registered state and count,
    // so a credit returned this cycle is usable no earlier than next cycle.
    assign active_s = (state_q == ACTIVE);
    assign s_ready  = active_s && (count_q != 4'd0);
    assign xfer_s   = s_valid && s_ready;
    // Credit returns during INIT are dropped: the count is already full.
    assign ret_s    = credit_ret && active_s;

    // Next-state logic for the reset-delay sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT0:   state_d = INIT1;
            INIT1:   state_d = ACTIVE;
            ACTIVE:  state_d = ACTIVE;
            default: state_d = INIT0;
        endcase
    end

    // Next credit count: simultaneous consume and return cancel out;
    // a return at full count saturates instead of wrapping.
    always_comb begin
        count_d = count_q;
        case ({xfer_s, ret_s})
            2'b10: count_d = count_q - 4'd1;
            2'b01: begin
                if (count_q >= CRED_MAX) begin
                    count_d = CRED_MAX;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
            default: count_d = count_q;
        endcase
    end

    // Next write-port values: one-clock latency, data held between writes.
    always_comb begin
        we_d   = xfer_s;
        data_d = data_q;
        if (xfer_s) begin
            data_d = s_data;
        end else begin
            data_d = data_q;
        end
    end

    // State, credit and write-port registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT0;
            count_q <= CRED_MAX;
            data_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            we_q    <= we_d;
        end
    end

    assign data_o  = data_q;
    assign data_we = we_q;
    assign credits = count_q;

`ifdef CREDIT_TX_OVERFLOW_CHECK_EN
    logic err_q;
    logic err_d;
    logic ovf_s;

    // Overflow: a return with the count full and no transfer freeing a slot.
    assign ovf_s = ret_s && !xfer_s && (count_q == CRED_MAX);

    // Sticky overflow flag next-state.
    always_comb begin
        err_d = err_q;
        if (ovf_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Sticky overflow flag register, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_credit_tx.sv
module tb_credit_tx;

    localparam int WIDTH   = 8;
    localparam int CREDITS = 4;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] data_o;
    logic             data_we;
    logic             credit_ret;
    logic [3:0]       credits;
    logic             err;

    int total;
    int bad;

    // Reference model: behaviour described in terms of clocks since reset
    // release, a credit integer and the last word written.
    int               m_edges;
    int               m_count;
    bit               m_we;
    logic [WIDTH-1:0] m_data;
    bit               m_err;
    bit               m_ovf_en;

    credit_tx #(.WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .data_o     (data_o),
        .data_we    (data_we),
        .credit_ret (credit_ret),
        .credits    (credits),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_ready();
        return (m_edges >= 2) && (m_count > 0);
    endfunction

    function automatic void model_reset();
        m_edges = 0;
        m_count = CREDITS;
        m_we    = 1'b0;
        m_data  = '0;
        m_err   = 1'b0;
    endfunction

    // Drive one cycle of inputs, clock once, advance the model (no checks).
    task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit r);
        bit xfer;
        bit ret;
        s_valid    = v;
        s_data     = d;
        credit_ret = r;
        xfer = v && model_ready();
        ret  = r && (m_edges >= 2);
        @(posedge clk);
        #1;
        if (ret && !xfer && m_count == CREDITS && m_ovf_en) m_err = 1'b1;
        if (xfer) m_count = m_count - 1;
        if (ret)  m_count = m_count + 1;
        if (m_count > CREDITS) m_count = CREDITS;
        m_we = xfer;
        if (xfer) m_data = d;
        m_edges++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        credit_ret = 1'b0;
        model_reset();
        #12;
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        total++; if (data_we !== 1'b0) begin bad++; $display("FAIL reset_data_we got=%b exp=0", data_we); end
        total++; if (data_o !== 8'h00) begin bad++; $display("FAIL reset_data_o got=%h exp=00", data_o); end
        total++; if (credits !== 4'd4) begin bad++; $display("FAIL reset_credits got=%0d exp=4", credits); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        reset_n = 1'b1;
    endtask

    task automatic test_init();
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            #1;
            total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL init_ready_low[%0d] got=%b exp=0", i, s_ready); end
            cycle(1'b1, 8'hA5, 1'b0);
            total++; if (data_we !== 1'b0) begin bad++; $display("FAIL init_no_write[%0d] got=%b exp=0", i, data_we); end
        end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL init_ready_high got=%b exp=1", s_ready); end
        cycle(1'b1, 8'hA5, 1'b0);
        total++; if (data_we !== 1'b1) begin bad++; $display("FAIL init_first_we got=%b exp=1", data_we); end
        total++; if (data_o !== 8'hA5) begin bad++; $display("FAIL init_first_data got=%h exp=a5", data_o); end
        total++; if (credits !== 4'd3) begin bad++; $display("FAIL init_credits got=%0d exp=3", credits); end
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] w;
        do_reset();
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            w = 8'h11 + 8'(i);
            cycle(1'b1, w, 1'b0);
            if (i < 4) begin
                total++; if (data_we !== 1'b1 || data_o !== w) begin bad++; $display("FAIL stream_word[%0d] got we=%b data=%h exp we=1 data=%h", i, data_we, data_o, w); end
            end else begin
                total++; if (data_we !== 1'b0 || data_o !== 8'h14) begin bad++; $display("FAIL stream_stall[%0d] got we=%b data=%h exp we=0 data=14", i, data_we, data_o); end
            end
        end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL stream_ready got=%b exp=0", s_ready); end
        total++; if (credits !== 4'd0) begin bad++; $display("FAIL stream_credits got=%0d exp=0", credits); end
    endtask

    task automatic test_credit_return();
        cycle(1'b1, 8'h15, 1'b1);
        total++; if (credits !== 4'd1) begin bad++; $display("FAIL ret_credits got=%0d exp=1", credits); end
        total++; if (data_we !== 1'b0) begin bad++; $display("FAIL ret_no_write got=%b exp=0", data_we); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL ret_ready got=%b exp=1", s_ready); end
        cycle(1'b1, 8'h15, 1'b0);
        total++; if (data_we !== 1'b1 || data_o !== 8'h15) begin bad++; $display("FAIL ret_accept got we=%b data=%h exp we=1 data=15", data_we, data_o); end
        total++; if (credits !== 4'd0) begin bad++; $display("FAIL ret_credits_after got=%0d exp=0", credits); end
    endtask

    task automatic test_simultaneous();
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        total++; if (credits !== 4'd2) begin bad++; $display("FAIL simul_pre_credits got=%0d exp=2", credits); end
        cycle(1'b1, 8'h3C, 1'b1);
        total++; if (credits !== 4'd2) begin bad++; $display("FAIL simul_credits got=%0d exp=2", credits); end
        total++; if (data_we !== 1'b1 || data_o !== 8'h3C) begin bad++; $display("FAIL simul_write got we=%b data=%h exp we=1 data=3c", data_we, data_o); end
    endtask

    task automatic test_overflow();
        bit exp_err;
        exp_err = m_ovf_en;
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        total++; if (credits !== 4'd4 || err !== 1'b0) begin bad++; $display("FAIL ovf_full got credits=%0d err=%b exp credits=4 err=0", credits, err); end
        cycle(1'b0, 8'h00, 1'b1);
        total++; if (credits !== 4'd4) begin bad++; $display("FAIL ovf_saturate got=%0d exp=4", credits); end
        total++; if (err !== exp_err) begin bad++; $display("FAIL ovf_err got=%b exp=%b", err, exp_err); end
        cycle(1'b1, 8'h77, 1'b0);
        total++; if (err !== exp_err || credits !== 4'd3) begin bad++; $display("FAIL ovf_sticky got err=%b credits=%0d exp err=%b credits=3", err, credits, exp_err); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b0);
        total++; if (credits !== 4'd1 || data_we !== 1'b1) begin bad++; $display("FAIL midrst_pre got credits=%0d we=%b exp credits=1 we=1", credits, data_we); end
        s_valid = 1'b1;
        reset_n = 1'b0;
        model_reset();
        #1;
        total++; if (data_we !== 1'b0 || credits !== 4'd4) begin bad++; $display("FAIL midrst_immediate got we=%b credits=%0d exp we=0 credits=4", data_we, credits); end
        total++; if (s_ready !== 1'b0 || err !== 1'b0 || data_o !== 8'h00) begin bad++; $display("FAIL midrst_outputs got ready=%b err=%b data=%h exp 0 0 00", s_ready, err, data_o); end
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL midrst_init_ready[%0d] got=%b exp=0", i, s_ready); end
            cycle(1'b1, 8'h66, 1'b1);
            total++; if (data_we !== 1'b0 || credits !== 4'd4) begin bad++; $display("FAIL midrst_init[%0d] got we=%b credits=%0d exp we=0 credits=4", i, data_we, credits); end
        end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL midrst_active got=%b exp=1", s_ready); end
    endtask

    task automatic test_random();
        bit               v;
        bit               r;
        logic [WIDTH-1:0] d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 9) < 4);
            d = 8'($urandom);
            total++; if (s_ready !== model_ready()) begin bad++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, s_ready, model_ready()); end
            cycle(v, d, r);
            total++;
            if (data_we !== m_we || data_o !== m_data || credits !== 4'(m_count) || err !== m_err) begin
                bad++;
                $display("FAIL rand_state[%0d] got we=%b data=%h credits=%0d err=%b exp we=%b data=%h credits=%0d err=%b",
                         i, data_we, data_o, credits, err, m_we, m_data, m_count, m_err);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
`ifdef CREDIT_TX_OVERFLOW_CHECK_EN
        m_ovf_en = 1'b1;
`else
        m_ovf_en = 1'b0;
`endif
        test_reset();
        test_init();
        test_stream();
        test_credit_return();
        test_simultaneous();
        test_overflow();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/credit_tx.md
CREDIT_TX -- requirements
Module: credit_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, 1..64.
REQ-002 SHALL have parameter CREDITS, default 4: initial and maximum credit count, 1..15; 4 matches a 4-entry downstream FIFO.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port s_data, input, WIDTH: upstream source data.
REQ-006 SHALL have port s_valid, input, 1: upstream data valid.
REQ-007 SHALL have port s_ready, output, 1: block accepts s_data this cycle.
REQ-008 SHALL have port data_o, output, WIDTH: data to the downstream FIFO write port.
REQ-009 SHALL have port data_we, output, 1: downstream FIFO write enable.
REQ-010 SHALL have port credit_ret, input, 1: one-cycle pulse, one per word the downstream consumer reads.
REQ-011 SHALL have port credits, output, 4: current credit count.
REQ-012 SHALL have port err, output, 1: sticky credit-overflow flag.

Function
REQ-013 SHALL implement FSM states INIT0, INIT1 and ACTIVE; INIT0->INIT1->ACTIVE on consecutive clocks; ACTIVE is held until reset.
REQ-014 The INIT states SHALL cover the downstream FIFO's registered-reset delay; no write SHALL be issued before ACTIVE.
REQ-015 s_ready SHALL be combinational: (state==ACTIVE) AND (credit count != 0), from the registered count only; no same-cycle credit_ret bypass.
REQ-016 A transfer SHALL occur when s_valid AND s_ready are 1 at a rising clk edge.
REQ-017 On a transfer, data_o SHALL take s_data and data_we SHALL be 1 in the next cycle; latency is exactly 1 clock.
REQ-018 When no transfer occurs, data_we SHALL be 0 the next cycle; data_o SHALL hold its last value.
REQ-019 Credit count SHALL update as follows: transfer only, -1; credit_ret only, +1; both, unchanged; neither, unchanged.
REQ-020 credit_ret SHALL be ignored in INIT0 and INIT1.
REQ-021 The credit count SHALL never underflow; REQ-015 guarantees no transfer occurs at 0.
REQ-022 Overflow (credit_ret with count==CREDITS and no transfer) SHALL leave the count at CREDITS (saturate); see REQ-027 for err.
REQ-023 Back-to-back transfers SHALL sustain 1 word/clock while credits remain.
REQ-024 credits SHALL equal the internal count at all times.

Reset
REQ-025 On reset_n=0, SHALL asynchronously set: state=INIT0, count=CREDITS, data_we=0, data_o=0, err=0; s_ready is therefore 0.
REQ-026 Reset asserted mid-stream SHALL discard in-flight state; there is no partial write: data_we=0 immediately, and counting restarts from CREDITS after release.

Configuration
REQ-027 With macro CREDIT_TX_OVERFLOW_CHECK_EN defined, an overflow event (REQ-022) SHALL set err=1 the next cycle; err stays 1 until reset.
REQ-028 Without CREDIT_TX_OVERFLOW_CHECK_EN, err SHALL be constant 0 and no overflow-detect logic is built; saturation per REQ-022 still applies.

Verification
REQ-029 Release reset with s_valid=1 held -> s_ready=0 for 2 clocks, then 1; first data_we one clock after the first accepted word.
REQ-030 CREDITS=4, stream 6 words 0x11..0x16, no credit_ret -> 0x11..0x14 written on consecutive clocks; s_ready=0; credits=0; 0x15 held upstream.
REQ-031 From credits=0, pulse credit_ret once -> credits=1 next cycle; 0x15 accepted the following cycle; credits back to 0.
REQ-032 credits=2, transfer and credit_ret in the same cycle -> credits stays 2; data_we=1 next cycle.
REQ-033 credits=4, idle, pulse credit_ret -> credits stays 4; err=1 with CREDIT_TX_OVERFLOW_CHECK_EN, err=0 without.
REQ-034 Assert reset_n=0 mid-stream at credits=1 -> data_we=0 and credits=4 immediately; INIT sequence repeats after release.
